// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared helpers for the synchronous FIFO family.
//   fifo_clog2     : ceiling log2 of a positive integer
//   fifo_depth     : number of words addressed by an addr_size-bit address
//   fifo_level_ok  : true when a threshold lies in 0..depth
//   FIFO_CHECK_LEVEL macro : elaboration-time threshold range guard
// -----------------------------------------------------------------------------
`ifndef FIFO_PKG_MACROS
`define FIFO_PKG_MACROS
// Expands to a generate block that stops elaboration when LVL is out of range.
`define FIFO_CHECK_LEVEL(LVL, DEP, LABEL) \
  if (!fifo_pkg::fifo_level_ok((LVL), (DEP))) begin : LABEL \
    $error("fifo threshold %0d outside 0..%0d", (LVL), (DEP)); \
  end
`endif

package fifo_pkg;

  function automatic int fifo_clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

  function automatic int fifo_depth(input int addr_size);
    return 1 << addr_size;
  endfunction

  function automatic bit fifo_level_ok(input int level, input int depth);
    return (level >= 0) && (level <= depth);
  endfunction

endpackage

// File: rtl/fifo_ram_reg.sv
// -----------------------------------------------------------------------------
// fifo_ram_reg
// 2**ADDR_SIZE x DATA_SIZE storage with synchronous write and a registered,
// enable-gated read port. Only the read register is reset.
//   wclk_i   : clock
//   wrst_i   : asynchronous active-high reset (clears rdata_o only)
//   wen_i    : write enable, waddr_i/wdata_i captured on the rising edge
//   ren_i    : read enable, mem[raddr_i] loaded into rdata_o on the rising edge
//   rdata_o  : registered read data, holds when ren_i is low
// -----------------------------------------------------------------------------
module fifo_ram_reg #(
  parameter int DATA_SIZE = 32,
  parameter int ADDR_SIZE = 6
) (
  input  logic                 wclk_i,
  input  logic                 wrst_i,
  input  logic                 wen_i,
  input  logic [ADDR_SIZE-1:0] waddr_i,
  input  logic [DATA_SIZE-1:0] wdata_i,
  input  logic                 ren_i,
  input  logic [ADDR_SIZE-1:0] raddr_i,
  output logic [DATA_SIZE-1:0] rdata_o
);

  localparam int DEPTH = fifo_pkg::fifo_depth(ADDR_SIZE);

  logic [DATA_SIZE-1:0] mem_q [DEPTH];
  logic [DATA_SIZE-1:0] rdata_q;

  // NOTE: the array has no reset so it maps onto plain RAM; stale words are
  // never observable because the pointers gate every read.
  always_ff @(posedge wclk_i) begin
    if (wen_i) mem_q[waddr_i] <= wdata_i;
  end

  // NOTE: non-blocking assignment keeps the read register race-free against
  // the same-edge write above.
  always_ff @(posedge wclk_i or posedge wrst_i) begin
    if (wrst_i)     rdata_q <= '0;
    else if (ren_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sync_fifo_reg.sv
// -----------------------------------------------------------------------------
// sync_fifo_reg
// Single-clock FIFO with registered read port, occupancy count, threshold
// flags and sticky error flags.
//   wclk          : clock for both sides (rising edge)
//   wrst          : asynchronous active-high reset, empties the FIFO
//   winc / wdata  : write request and data (dropped while full)
//   rinc          : read request (ignored while empty)
//   rdata/rvalid  : popped word, valid one cycle after an accepted rinc
//   wfull, walmost_full, rempty, ralmost_empty, count : status from pointers
//   overflow/underflow : sticky error flags, cleared by clr_err
// -----------------------------------------------------------------------------
module sync_fifo_reg
  import fifo_pkg::*;
#(
  parameter int DATA_SIZE = 32,
  parameter int ADDR_SIZE = 6,
  parameter int AF_LEVEL  = (1 << ADDR_SIZE) - 4,
  parameter int AE_LEVEL  = 4
) (
  input  logic                 wclk,
  input  logic                 wrst,
  input  logic                 winc,
  input  logic [DATA_SIZE-1:0] wdata,
  input  logic                 rinc,
  output logic [DATA_SIZE-1:0] rdata,
  output logic                 rvalid,
  output logic                 wfull,
  output logic                 walmost_full,
  output logic                 rempty,
  output logic                 ralmost_empty,
  output logic [ADDR_SIZE:0]   count,
  output logic                 overflow,
  output logic                 underflow,
  input  logic                 clr_err
);

  localparam int DEPTH = fifo_depth(ADDR_SIZE);

  `FIFO_CHECK_LEVEL(AF_LEVEL, DEPTH, g_bad_af_level)
  `FIFO_CHECK_LEVEL(AE_LEVEL, DEPTH, g_bad_ae_level)

  // Thresholds fit in ADDR_SIZE+1 bits once range-checked.
  localparam logic [ADDR_SIZE:0] DEPTH_V = DEPTH[ADDR_SIZE:0];
  localparam logic [ADDR_SIZE:0] AF_V    = AF_LEVEL[ADDR_SIZE:0];
  localparam logic [ADDR_SIZE:0] AE_V    = AE_LEVEL[ADDR_SIZE:0];

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [ADDR_SIZE:0] wptr_q, wptr_d;
  logic [ADDR_SIZE:0] rptr_q, rptr_d;
  logic               rvalid_q, rvalid_d;
  logic               overflow_q, overflow_d;
  logic               underflow_q, underflow_d;
  logic               wen, ren;

  // Status derives only from registered pointers: no winc/rinc path.
  assign count         = wptr_q - rptr_q;
  assign wfull         = (count == DEPTH_V);
  assign rempty        = (wptr_q == rptr_q);
  assign walmost_full  = (count >= AF_V);
  assign ralmost_empty = (count <= AE_V);

  assign wen = winc && !wfull;
  assign ren = rinc && !rempty;

  // NOTE: every output of this block gets a default first, so no latch forms.
  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    rvalid_d    = ren;
    overflow_d  = overflow_q  | (winc && wfull);
    underflow_d = underflow_q | (rinc && rempty);
    if (wen) wptr_d = wptr_q + 1'b1;
    if (ren) rptr_d = rptr_q + 1'b1;
    // Clearing wins over a same-cycle error.
    if (clr_err) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
  end

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      rvalid_q    <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      rvalid_q    <= rvalid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign rvalid    = rvalid_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

  fifo_ram_reg #(
    .DATA_SIZE (DATA_SIZE),
    .ADDR_SIZE (ADDR_SIZE)
  ) u_ram (
    .wclk_i  (wclk),
    .wrst_i  (wrst),
    .wen_i   (wen),
    .waddr_i (wptr_q[ADDR_SIZE-1:0]),
    .wdata_i (wdata),
    .ren_i   (ren),
    .raddr_i (rptr_q[ADDR_SIZE-1:0]),
    .rdata_o (rdata)
  );

endmodule

// File: tb/tb_sync_fifo_reg.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo_reg
// Directed bench for sync_fifo_reg with DEPTH=4, AF_LEVEL=3, AE_LEVEL=1.
// -----------------------------------------------------------------------------
module tb_sync_fifo_reg;

  localparam int DW = 8;
  localparam int AW = 2;

  logic          wclk = 1'b0;
  logic          wrst = 1'b0;
  logic          winc = 1'b0;
  logic [DW-1:0] wdata = '0;
  logic          rinc = 1'b0;
  logic          clr_err = 1'b0;
  logic [DW-1:0] rdata;
  logic          rvalid, wfull, walmost_full, rempty, ralmost_empty;
  logic [AW:0]   count;
  logic          overflow, underflow;

  int n_checks = 0;
  int n_fail   = 0;

  sync_fifo_reg #(
    .DATA_SIZE (DW),
    .ADDR_SIZE (AW),
    .AF_LEVEL  (3),
    .AE_LEVEL  (1)
  ) dut (
    .wclk          (wclk),
    .wrst          (wrst),
    .winc          (winc),
    .wdata         (wdata),
    .rinc          (rinc),
    .rdata         (rdata),
    .rvalid        (rvalid),
    .wfull         (wfull),
    .walmost_full  (walmost_full),
    .rempty        (rempty),
    .ralmost_empty (ralmost_empty),
    .count         (count),
    .overflow      (overflow),
    .underflow     (underflow),
    .clr_err       (clr_err)
  );

  always #5 wclk = ~wclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge, then settle 1 time unit before sampling.
  task automatic step();
    @(posedge wclk);
    #1;
  endtask

  logic [DW-1:0] wr_vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  logic [DW-1:0] exp_q [$];

  initial begin
    // ---- reset ----
    #2 wrst = 1'b1;
    @(posedge wclk);
    #1 wrst = 1'b0;
    #1;
    check("rst_count", 32'(count), 0);
    check("rst_rempty", 32'(rempty), 1);
    check("rst_wfull", 32'(wfull), 0);
    check("rst_afull", 32'(walmost_full), 0);
    check("rst_aempty", 32'(ralmost_empty), 1);
    check("rst_rvalid", 32'(rvalid), 0);
    check("rst_rdata", 32'(rdata), 0);
    check("rst_ovf", 32'(overflow), 0);
    check("rst_udf", 32'(underflow), 0);

    // ---- 1: fill ----
    for (int i = 0; i < 4; i++) begin
      winc = 1'b1; wdata = wr_vals[i];
      step();
      check("fill_count", 32'(count), 32'(i + 1));
      check("fill_afull", 32'(walmost_full), 32'(i + 1 >= 3));
      check("fill_wfull", 32'(wfull), 32'(i == 3));
      check("fill_rempty", 32'(rempty), 0);
      check("fill_aempty", 32'(ralmost_empty), 32'(i == 0));
      check("fill_rvalid", 32'(rvalid), 0);
    end

    // ---- 3: overflow on full ----
    winc = 1'b1; wdata = 8'h55;
    step();
    winc = 1'b0;
    check("ovf_count", 32'(count), 4);
    check("ovf_flag", 32'(overflow), 1);
    check("ovf_wfull", 32'(wfull), 1);
    step();
    check("ovf_sticky", 32'(overflow), 1);
    // clear has priority over a same-cycle overflow
    clr_err = 1'b1; winc = 1'b1; wdata = 8'h66;
    step();
    clr_err = 1'b0; winc = 1'b0;
    check("ovf_clr", 32'(overflow), 0);
    check("ovf_clr_count", 32'(count), 4);

    // ---- 2: drain ----
    for (int i = 0; i < 4; i++) begin
      rinc = 1'b1;
      step();
      check("drain_rvalid", 32'(rvalid), 1);
      check("drain_rdata", 32'(rdata), 32'(wr_vals[i]));
      check("drain_count", 32'(count), 32'(3 - i));
      check("drain_rempty", 32'(rempty), 32'(i == 3));
      check("drain_aempty", 32'(ralmost_empty), 32'(i >= 2));
      check("drain_afull", 32'(walmost_full), 32'(i == 0));
    end
    rinc = 1'b0;
    step();
    check("idle_rvalid", 32'(rvalid), 0);
    check("idle_rdata_hold", 32'(rdata), 32'h44);
    check("idle_udf", 32'(underflow), 0);

    // ---- 4: simultaneous read/write while empty ----
    winc = 1'b1; rinc = 1'b1; wdata = 8'hA5;
    step();
    winc = 1'b0;
    check("empty_rw_rvalid", 32'(rvalid), 0);
    check("empty_rw_udf", 32'(underflow), 1);
    check("empty_rw_count", 32'(count), 1);
    check("empty_rw_rdata_hold", 32'(rdata), 32'h44);
    step();
    rinc = 1'b0;
    check("empty_rw_rd_rvalid", 32'(rvalid), 1);
    check("empty_rw_rd_rdata", 32'(rdata), 32'hA5);
    check("empty_rw_rd_count", 32'(count), 0);
    check("udf_sticky", 32'(underflow), 1);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    check("udf_clr", 32'(underflow), 0);

    // ---- 5: steady read/write at count 2 across pointer wrap ----
    for (int i = 0; i < 2; i++) begin
      winc = 1'b1; wdata = 8'(i + 1);
      exp_q.push_back(8'(i + 1));
      step();
    end
    for (int i = 0; i < 10; i++) begin
      winc = 1'b1; rinc = 1'b1; wdata = 8'(i + 3);
      exp_q.push_back(8'(i + 3));
      step();
      check("stream_count", 32'(count), 2);
      check("stream_rvalid", 32'(rvalid), 1);
      check("stream_rdata", 32'(rdata), 32'(exp_q.pop_front()));
    end
    winc = 1'b0; rinc = 1'b0;
    check("stream_ovf", 32'(overflow), 0);
    check("stream_udf", 32'(underflow), 0);

    // ---- 6: reset mid-stream ----
    winc = 1'b1; wdata = 8'h0D;
    step();
    winc = 1'b1; rinc = 1'b1; wdata = 8'h0E;
    step();
    winc = 1'b0; rinc = 1'b0;
    check("pre_rst_count", 32'(count), 3);
    check("pre_rst_rvalid", 32'(rvalid), 1);
    check("pre_rst_rdata", 32'(rdata), 32'h0B);
    #2 wrst = 1'b1;
    #1;
    check("midrst_count", 32'(count), 0);
    check("midrst_rempty", 32'(rempty), 1);
    check("midrst_rvalid", 32'(rvalid), 0);
    check("midrst_rdata", 32'(rdata), 0);
    #1 wrst = 1'b0;
    winc = 1'b1; wdata = 8'h77;
    step();
    winc = 1'b0;
    check("post_rst_count", 32'(count), 1);
    rinc = 1'b1;
    step();
    rinc = 1'b0;
    check("post_rst_rvalid", 32'(rvalid), 1);
    check("post_rst_rdata", 32'(rdata), 32'h77);
    check("post_rst_rempty", 32'(rempty), 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
